// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding
// and the width of the wait-state counter.
package dmem_pkg;

    localparam int WAIT_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage behind the responder. Writes land on the rising edge when
// we_i is high and reads are combinational. There is no reset, so contents
// survive a reset of the surrounding logic.
module dmem_array #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [2**AW];

    // Commit a store word when the responder raises the write strobe
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder. A request is latched in IDLE,
// held for WAIT cycles, then committed against the array. The result is
// presented until the initiator takes it. Addresses with any bit set above
// the index range are rejected with resp_err and never touch the array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int W    = 32,
    parameter int AW   = 8,
    parameter int WAIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err
);

    state_e             state_q, state_d;
    logic [WAIT_CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]       addr_q, addr_d;
    logic [W-1:0]       wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [W-1:0]       rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               inRange;
    logic               memWe;
    logic [W-1:0]       memRdata;

    assign inRange = (addr_q[W-1:AW] == '0);

    dmem_array #(
        .W  (W),
        .AW (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (memWe),
        .waddr_i (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[AW-1:0]),
        .rdata_o (memRdata)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, commit when the
    // count reaches zero, then hold the response until it is consumed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        memWe   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    cnt_d   = WAIT_CW'(WAIT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CW'(1);
                end else begin
                    memWe   = we_q & inRange;
                    rdata_d = (!we_q && inRange) ? memRdata : '0;
                    err_d   = ~inRange;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any uncommitted access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 1 runs with two wait states,
// instance 0 with none. Inputs change and outputs are sampled on the
// falling edge.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [1:0]  reqWe;
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic [1:0]  respValid;
    logic [1:0]  respReady;
    logic [31:0] respRdata [2];
    logic [1:0]  respErr;

    int errors = 0;
    int checks = 0;

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    dmem_responder #(.W(32), .AW(8), .WAIT(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid[0]),
        .req_ready  (reqReady[0]),
        .req_we     (reqWe[0]),
        .req_addr   (reqAddr[0]),
        .req_wdata  (reqWdata[0]),
        .resp_valid (respValid[0]),
        .resp_ready (respReady[0]),
        .resp_rdata (respRdata[0]),
        .resp_err   (respErr[0])
    );

    dmem_responder #(.W(32), .AW(8), .WAIT(2)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid[1]),
        .req_ready  (reqReady[1]),
        .req_we     (reqWe[1]),
        .req_addr   (reqAddr[1]),
        .req_wdata  (reqWdata[1]),
        .resp_valid (respValid[1]),
        .resp_ready (respReady[1]),
        .resp_rdata (respRdata[1]),
        .resp_err   (respErr[1])
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance s and return once its response is up,
    // checking the response latency measured from the accepting edge
    task automatic applyStimulus(input int s, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int expLat, input string tag);
        int lat;
        @(negedge clk);
        checkOutput({tag, "_ready"}, {31'd0, reqReady[s]}, 32'd1);
        reqValid[s] = 1'b1;
        reqWe[s]    = we;
        reqAddr[s]  = addr;
        reqWdata[s] = wdata;
        @(posedge clk);
        @(negedge clk);
        reqValid[s] = 1'b0;
        reqWe[s]    = ~we;
        reqAddr[s]  = 32'hFFFF_FFFF;
        reqWdata[s] = 32'h0;
        lat = 0;
        while (!respValid[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, lat, expLat);
    endtask

    // Consume the pending response on instance s
    task automatic finishResp(input int s, input string tag);
        respReady[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        respReady[s] = 1'b0;
        checkOutput({tag, "_vdone"}, {31'd0, respValid[s]}, 32'd0);
        checkOutput({tag, "_rdone"}, {31'd0, reqReady[s]}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '0;
        reqWe     = '0;
        respReady = '0;
        for (int i = 0; i < 2; i++) begin
            reqAddr[i]  = '0;
            reqWdata[i] = '0;
        end

        // Reset values
        #2;
        checkOutput("rst_ready",  {31'd0, reqReady[1]},  32'd1);
        checkOutput("rst_valid",  {31'd0, respValid[1]}, 32'd0);
        checkOutput("rst_rdata",  respRdata[1],          32'd0);
        checkOutput("rst_err",    {31'd0, respErr[1]},   32'd0);
        checkOutput("rst_ready0", {31'd0, reqReady[0]},  32'd1);

        // Release and sit idle
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_valid", {31'd0, respValid[1]}, 32'd0);
        checkOutput("idle_ready", {31'd0, reqReady[1]},  32'd1);

        // Store then load with two wait states
        applyStimulus(1, 1'b1, 32'h05, 32'hDEAD_BEEF, 3, "st05");
        checkOutput("st05_err",   {31'd0, respErr[1]}, 32'd0);
        checkOutput("st05_rdata", respRdata[1],        32'd0);
        finishResp(1, "st05");
        applyStimulus(1, 1'b0, 32'h05, 32'h0, 3, "ld05");
        checkOutput("ld05_err",   {31'd0, respErr[1]}, 32'd0);
        checkOutput("ld05_rdata", respRdata[1],        32'hDEAD_BEEF);
        finishResp(1, "ld05");

        // Out-of-range store must not alias onto index 0
        applyStimulus(1, 1'b1, 32'h00, 32'h1111_1111, 3, "st00");
        finishResp(1, "st00");
        applyStimulus(1, 1'b1, 32'h100, 32'h0BAD_F00D, 3, "st100");
        checkOutput("st100_err",   {31'd0, respErr[1]}, 32'd1);
        checkOutput("st100_rdata", respRdata[1],        32'd0);
        finishResp(1, "st100");
        applyStimulus(1, 1'b0, 32'h00, 32'h0, 3, "ld00");
        checkOutput("ld00_rdata", respRdata[1],        32'h1111_1111);
        checkOutput("ld00_err",   {31'd0, respErr[1]}, 32'd0);
        finishResp(1, "ld00");
        applyStimulus(1, 1'b0, 32'h100, 32'h0, 3, "ld100");
        checkOutput("ld100_err",   {31'd0, respErr[1]}, 32'd1);
        checkOutput("ld100_rdata", respRdata[1],        32'd0);
        finishResp(1, "ld100");

        // Backpressure: response held while the request lines wander
        applyStimulus(1, 1'b0, 32'h05, 32'h0, 3, "bp");
        for (int c = 0; c < 10; c++) begin
            reqValid[1] = 1'b1;
            reqWe[1]    = 1'b1;
            reqAddr[1]  = 32'($urandom_range(0, 255));
            reqWdata[1] = $urandom;
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, respValid[1]}, 32'd1);
            checkOutput("bp_rdata", respRdata[1],          32'hDEAD_BEEF);
            checkOutput("bp_err",   {31'd0, respErr[1]},   32'd0);
            checkOutput("bp_ready", {31'd0, reqReady[1]},  32'd0);
        end
        reqValid[1] = 1'b0;
        finishResp(1, "bp");
        applyStimulus(1, 1'b0, 32'h05, 32'h0, 3, "bp_ld");
        checkOutput("bp_ld_rdata", respRdata[1], 32'hDEAD_BEEF);
        finishResp(1, "bp_ld");

        // Zero wait states: preload, then two back-to-back loads
        applyStimulus(0, 1'b1, 32'h03, 32'hA5A5_A5A5, 1, "w0st03");
        finishResp(0, "w0st03");
        applyStimulus(0, 1'b1, 32'h04, 32'h5A5A_5A5A, 1, "w0st04");
        finishResp(0, "w0st04");
        @(negedge clk);
        reqValid[0]  = 1'b1;
        reqWe[0]     = 1'b0;
        reqAddr[0]   = 32'h03;
        respReady[0] = 1'b1;
        @(negedge clk);
        checkOutput("b2b_v0",  {31'd0, respValid[0]}, 32'd0);
        checkOutput("b2b_rd0", {31'd0, reqReady[0]},  32'd0);
        @(negedge clk);
        checkOutput("b2b_v1",  {31'd0, respValid[0]}, 32'd1);
        checkOutput("b2b_d1",  respRdata[0],          32'hA5A5_A5A5);
        reqAddr[0] = 32'h04;
        @(negedge clk);
        checkOutput("b2b_v2",  {31'd0, respValid[0]}, 32'd0);
        checkOutput("b2b_rd2", {31'd0, reqReady[0]},  32'd1);
        @(negedge clk);
        checkOutput("b2b_rd3", {31'd0, reqReady[0]},  32'd0);
        checkOutput("b2b_v3",  {31'd0, respValid[0]}, 32'd0);
        reqValid[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b_v4",  {31'd0, respValid[0]}, 32'd1);
        checkOutput("b2b_d4",  respRdata[0],          32'h5A5A_5A5A);
        @(negedge clk);
        respReady[0] = 1'b0;
        checkOutput("b2b_v5",  {31'd0, respValid[0]}, 32'd0);

        // Reset during WAIT drops the pending store
        applyStimulus(1, 1'b1, 32'h07, 32'hCAFE_F00D, 3, "st07a");
        finishResp(1, "st07a");
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b1;
        reqAddr[1]  = 32'h07;
        reqWdata[1] = 32'h1234_5678;
        @(negedge clk);
        reqValid[1] = 1'b0;
        checkOutput("mid_wait_ready", {31'd0, reqReady[1]}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'd0, reqReady[1]},  32'd1);
        checkOutput("mid_rst_valid", {31'd0, respValid[1]}, 32'd0);
        checkOutput("mid_rst_rdata", respRdata[1],          32'd0);
        checkOutput("mid_rst_err",   {31'd0, respErr[1]},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_valid", {31'd0, respValid[1]}, 32'd0);
        applyStimulus(1, 1'b0, 32'h07, 32'h0, 3, "ld07");
        checkOutput("ld07_rdata", respRdata[1],        32'hCAFE_F00D);
        checkOutput("ld07_err",   {31'd0, respErr[1]}, 32'd0);
        finishResp(1, "ld07");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
